// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer for the 16-bit RISC datapath: walks fetch/decode/execute/memory/writeback,
// owns the instruction/data memory handshakes, the request timeout and halt/resume.
module cpu_sequencer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       memr,
  input  logic       memw,
  input  logic       regw_en,
  input  logic       b,
  input  logic       jmp,
  input  logic       hlt,
  input  logic       upd_flag,
  input  logic       br_taken,
  input  logic       mem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       rf_we,
  output logic       flag_we,
  output logic       halted,
  output logic       mem_timeout,
  output logic [2:0] state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       run_q;
  logic [7:0] wait_cnt;
  logic       timeout_q;
  logic       run_edge;
  logic       req_active;
  logic       tmo_hit;

  assign run_edge   = run & ~run_q;
  assign req_active = (state_q == S_FETCH) || (state_q == S_MEM);
  // A same-cycle ack always beats the timeout.
  assign tmo_hit    = req_active & ~mem_ack & (wait_cnt == 8'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (run_edge) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack)      state_d = S_DECODE;
        else if (tmo_hit) state_d = S_HALT;
      end
      S_DECODE: begin
        if (hlt)      state_d = S_HALT;
        else if (jmp) state_d = S_FETCH;
        else          state_d = S_EXEC;
      end
      S_EXEC: begin
        if (b)                state_d = S_FETCH;
        else if (memr | memw) state_d = S_MEM;
        else if (regw_en)     state_d = S_WB;
        else                  state_d = S_FETCH;
      end
      S_MEM: begin
        if (mem_ack)      state_d = memr ? S_WB : S_FETCH;
        else if (tmo_hit) state_d = S_HALT;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (run_edge) state_d = S_FETCH;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_load  = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    rf_we    = 1'b0;
    flag_we  = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = mem_ack;
        pc_inc   = mem_ack;
      end
      S_DECODE: begin
        pc_load = jmp & ~hlt;
      end
      S_EXEC: begin
        flag_we = upd_flag;
        pc_load = b & br_taken;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = memw;
      end
      S_WB: begin
        rf_we = 1'b1;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      run_q     <= 1'b0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run;
      // Counter restarts on every entry into a requesting state.
      if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM)))
        wait_cnt <= '0;
      else if (req_active && !mem_ack)
        wait_cnt <= wait_cnt + 8'd1;
      if (tmo_hit)
        timeout_q <= 1'b1;
    end
  end

  assign mem_timeout = timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: an instruction-level model expands each instruction into its expected
// per-cycle trace (state, strobes, ack stimulus) which is then played against the DUT.
module tb_cpu_sequencer;

  localparam int TMO = 15;

  logic       clk = 1'b0;
  logic       rst_n, run, memr, memw, regw_en, b, jmp, hlt, upd_flag, br_taken, mem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load, rf_we, flag_we;
  logic       halted, mem_timeout;
  logic [2:0] state;

  always #5 clk = ~clk;

  cpu_sequencer #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .memr(memr), .memw(memw), .regw_en(regw_en),
    .b(b), .jmp(jmp), .hlt(hlt), .upd_flag(upd_flag), .br_taken(br_taken), .mem_ack(mem_ack),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .rf_we(rf_we), .flag_we(flag_we), .halted(halted),
    .mem_timeout(mem_timeout), .state(state)
  );

  typedef struct packed {
    logic [2:0] st;
    logic imem, dmem, we, irl, pci, pcl, rfwe, flwe, hal, to;
  } outs_t;

  typedef struct packed {
    outs_t o;
    logic  ack;
    logic  run;
  } ent_t;

  typedef struct packed {
    logic memr, memw, regw, b, jmp, hlt, upd, br;
  } flags_t;

  typedef enum int {OP_ALU, OP_LOAD, OP_STORE, OP_CMP, OP_BR, OP_JMP, OP_NOP, OP_HLT} op_e;

  ent_t  q[$];
  logic  exp_to;
  int    checks = 0;
  int    errors = 0;
  string tag;

  function automatic outs_t actual();
    return outs_t'({state, imem_req, dmem_req, dmem_we, ir_load, pc_inc, pc_load,
                    rf_we, flag_we, halted, mem_timeout});
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // Encodings are the architectural debug codes: 0 idle, 1 fetch, 2 decode, 3 exec, 4 mem, 5 wb, 6 halt.
  function automatic void push(logic [2:0] st, logic ack, logic imem, logic dmem, logic we,
                               logic irl, logic pci, logic pcl, logic rfwe, logic flwe, logic rn);
    ent_t e;
    e.o.st = st;   e.o.imem = imem; e.o.dmem = dmem; e.o.we = we;
    e.o.irl = irl; e.o.pci = pci;   e.o.pcl = pcl;   e.o.rfwe = rfwe;
    e.o.flwe = flwe; e.o.hal = (st == 3'd6); e.o.to = exp_to;
    e.ack = ack; e.run = rn;
    q.push_back(e);
  endfunction

  function automatic flags_t flags_of(op_e op, logic br);
    flags_t f;
    f = '0;
    f.br = br;
    case (op)
      OP_ALU:   f.regw = 1'b1;
      OP_LOAD:  begin f.memr = 1'b1; f.regw = 1'b1; end
      OP_STORE: f.memw = 1'b1;
      OP_CMP:   f.upd = 1'b1;
      OP_BR:    f.b = 1'b1;
      OP_JMP:   f.jmp = 1'b1;
      OP_HLT:   begin f.hlt = 1'b1; f.jmp = rnd(); end
      default:  ;
    endcase
    return f;
  endfunction

  // Expands one instruction; fw/mw are wait cycles before ack. Returns 1 if it ends halted.
  function automatic logic model_instr(flags_t f, int fw, int mw);
    int n;
    logic a;
    n = (fw > TMO) ? TMO : fw;
    for (int i = 0; i <= n; i++) begin
      a = (i == fw);
      push(3'd1, a, 1'b1, 1'b0, 1'b0, a, a, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    if (fw > TMO) begin
      exp_to = 1'b1;
      return 1'b1;
    end
    push(3'd2, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, f.jmp & ~f.hlt, 1'b0, 1'b0, 1'b1);
    if (f.hlt) return 1'b1;
    if (f.jmp) return 1'b0;
    push(3'd3, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, f.b & f.br, 1'b0, f.upd, 1'b1);
    if (f.b) return 1'b0;
    if (f.memr | f.memw) begin
      n = (mw > TMO) ? TMO : mw;
      for (int i = 0; i <= n; i++) begin
        a = (i == mw);
        push(3'd4, a, 1'b0, 1'b1, f.memw, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      if (mw > TMO) begin
        exp_to = 1'b1;
        return 1'b1;
      end
      if (f.memr) push(3'd5, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      return 1'b0;
    end
    if (f.regw) push(3'd5, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    return 1'b0;
  endfunction

  // Halted with run still high for 'hold' cycles, then a low cycle and a rising edge.
  function automatic void model_resume(int hold);
    for (int i = 0; i < hold; i++)
      push(3'd6, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    push(3'd6, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    push(3'd6, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic check(outs_t exp);
    outs_t act;
    act = actual();
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s t=%0t observed=%b expected=%b (st,imem,dmem,we,irl,pci,pcl,rfwe,flwe,hal,to)",
             tag, $time, act, exp);
    end
  endtask

  task automatic run_trace(flags_t f);
    ent_t e;
    int   i;
    i = 0;
    while (q.size() > 0) begin
      e = q.pop_front();
      @(negedge clk);
      if (i == 0) begin
        memr = f.memr; memw = f.memw; regw_en = f.regw; b = f.b;
        jmp = f.jmp; hlt = f.hlt; upd_flag = f.upd; br_taken = f.br;
      end
      mem_ack = e.ack;
      run     = e.run;
      #1;
      check(e.o);
      i++;
    end
  endtask

  task automatic exec(string t, flags_t f, int fw, int mw, int hold);
    tag = t;
    if (model_instr(f, fw, mw)) model_resume(hold);
    run_trace(f);
  endtask

  task automatic do_reset();
    tag = "reset";
    @(negedge clk);
    rst_n = 1'b0;
    run = 1'b0;
    mem_ack = rnd();
    repeat (2) begin
      @(posedge clk);
      #1;
      check('0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_to = 1'b0;
    #1;
    check('0);
    push(3'd0, rnd(), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    op_e    op;
    flags_t f;
    int     fw, mw;

    rst_n = 1'b0; run = 1'b0; mem_ack = 1'b0;
    memr = 1'b0; memw = 1'b0; regw_en = 1'b0; b = 1'b0;
    jmp = 1'b0; hlt = 1'b0; upd_flag = 1'b0; br_taken = 1'b0;
    exp_to = 1'b0;

    do_reset();
    exec("add",          flags_of(OP_ALU, 1'b0),   0, 0, 1);
    exec("load_w3",      flags_of(OP_LOAD, 1'b0),  0, 3, 1);
    exec("store_w3",     flags_of(OP_STORE, 1'b0), 0, 3, 1);
    exec("b_taken",      flags_of(OP_BR, 1'b1),    0, 0, 1);
    exec("b_not_taken",  flags_of(OP_BR, 1'b0),    0, 0, 1);
    exec("cmp",          flags_of(OP_CMP, 1'b1),   0, 0, 1);
    exec("jmp",          flags_of(OP_JMP, 1'b0),   0, 0, 1);
    exec("nop",          flags_of(OP_NOP, 1'b1),   0, 0, 1);
    exec("fetch_ack_16", flags_of(OP_ALU, 1'b0),   TMO, 0, 1);
    exec("mem_ack_16",   flags_of(OP_LOAD, 1'b0),  0, TMO, 1);
    exec("hlt_run_held", flags_of(OP_HLT, 1'b0),   1, 0, 4);
    exec("fetch_tmo",    flags_of(OP_ALU, 1'b0),   TMO + 5, 0, 2);
    exec("post_tmo_add", flags_of(OP_ALU, 1'b0),   0, 0, 1);
    exec("mem_tmo",      flags_of(OP_STORE, 1'b0), 1, TMO + 3, 2);
    do_reset();

    for (int k = 0; k < 150; k++) begin
      op = op_e'($urandom_range(0, 7));
      fw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TMO - 1, TMO + 3)) : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 19) == 0) ? int'($urandom_range(TMO - 1, TMO + 3)) : int'($urandom_range(0, 3));
      exec($sformatf("rand%0d_op%0d", k, int'(op)), flags_of(op, rnd()), fw, mw,
           int'($urandom_range(1, 3)));
    end

    // Reset lands while a data request is outstanding.
    do_reset();
    exec("pre_rst_add", flags_of(OP_ALU, 1'b0), 0, 0, 1);
    tag = "rst_mid_mem";
    f = flags_of(OP_LOAD, 1'b0);
    void'(model_instr(f, 0, 10));
    while (q.size() > 5) void'(q.pop_back());
    run_trace(f);
    do_reset();
    exec("after_rst_add", flags_of(OP_ALU, 1'b0), 1, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
